sl3_rx_am_check: RTL and testbench
==================================

Name: sl3_rx_am_check

Overview:
- Sits directly downstream of the armored 66-bit receive lane array, on the recovered core clock.
- Consumes deskewed NUM_LN x 66-bit words and locates the alignment-marker (AM) beats.
- Checks AM periodicity and cross-lane consistency, strips AM beats from the data stream, and accumulates corrected/uncorrected ECC error counts for status readout.

Parameters:
NUM_LN, 4, number of lanes (66 bits each in din/dout)
AM_PERIOD, 1024, valid beats from one AM beat to the next (AM beat included); power of 2, >= 4
MISS_LIMIT, 3, consecutive AM misses in LOCKED that drop back to HUNT; range 1..7
CNT_W, 16, width of saturating error counters

Ports:
clk  in  1  core clock (recovered rx clock)
srst  in  1  synchronous active-high reset
din  in  NUM_LN*66  lane words; lane i at [i*66+65:i*66], sync header in bits [1:0]
din_valid  in  1  din beat qualifier (nominally every other cycle)
din_fix  in  NUM_LN  per-lane corrected-error flag, sampled every cycle
din_fail  in  NUM_LN  per-lane uncorrected-error flag, sampled every cycle
deskew_locked  in  1  cross-lane deskew lock status
clr_cnt  in  1  clears fix_cnt/fail_cnt
dout  out  NUM_LN*66  data beats with AM beats removed
dout_valid  out  1  dout qualifier
am_locked  out  1  high in LOCKED state
am_miss  out  1  one-cycle pulse: AM absent where expected, or AM at an unexpected beat
am_mismatch  out  1  one-cycle pulse: AM on some lanes but not all
am_lane_err  out  1  one-cycle pulse: AM lane-ID error (optional feature; else 0)
fix_cnt  out  CNT_W  saturating count of lane-corrections
fail_cnt  out  CNT_W  saturating count of lane-failures

Behaviour:
- Clocking/reset: one clock `clk`; `srst` is synchronous, active-high.
- Reset values: all outputs 0, state IDLE, beat counter 0, miss count 0.
- Lane AM detect (combinational): din[i*66]==1 and din[i*66+37:i*66+34]==4'b1100. all_am = AND over lanes; any_am = OR over lanes.
- State machine, evaluated only on din_valid beats except where noted:
  - IDLE: entered from any state in the cycle after deskew_locked is seen low. Clears miss count; no output. Leaves to HUNT when deskew_locked is high.
  - HUNT: beat with all_am -> LOCKED; beat counter set to 1.
  - LOCKED: beat counter increments per valid beat, modulo AM_PERIOD. An AM is expected when the counter is 0.
    - Expected beat with all_am: miss count cleared.
    - Expected beat without all_am: am_miss pulse; miss count +1.
    - all_am at an unexpected beat: am_miss pulse; miss count +1; counter realigned to 1.
    - When miss count reaches MISS_LIMIT: go to HUNT and clear miss count.
- Partial AM: any_am && !all_am gives an am_mismatch pulse in any non-IDLE state. The beat is treated as data.
- Output:
  - dout is din registered, latency 1 cycle.
  - dout_valid = registered (din_valid && state==LOCKED && !all_am).
  - AM beats are never forwarded. Nothing is forwarded in IDLE or HUNT.
  - dout holds its last value when dout_valid is low.
- Counters:
  - Every cycle, fix_cnt += popcount(din_fix) and fail_cnt += popcount(din_fail), saturating at all-ones.
  - If clr_cnt is high, both counters load 0 and that cycle's increments are discarded.
  - srst also clears both counters.
- Pulses: am_miss, am_mismatch and am_lane_err are registered and aligned with the dout beat they describe.
- Simultaneous events:
  - srst overrides everything.
  - deskew_locked low overrides an AM decision in the same cycle.
  - Miss-limit exit and the am_miss pulse occur together.

Optional Feature:
- Macro: SL3_AM_LANE_ID_EN.
- Defined: for each lane with an AM, bits [i*66+45:i*66+38] must equal i (8-bit).
  - Any mismatch on an all_am beat pulses am_lane_err.
  - That beat is then treated as not-AM for state purposes, i.e. it counts as a miss in LOCKED and gives no lock in HUNT.
  - The beat is still stripped from dout.
- Not defined: the lane-ID field is ignored and am_lane_err is tied to 0. The port remains present.

Decomposition:
- Shared package sl3_pkg:
  - AM block-type constant (4'b1100) and control sync header constant (2'b01).
  - AM lane-ID field offsets.
  - State enum (IDLE, HUNT, LOCKED).
- One sub-module, sl3_sat_popcnt_acc: popcount plus saturating accumulator with clear; instantiated twice.

Test Plan:
- Reset, then deskew_locked=1 with AM on all lanes at beat 0, then 1023 data beats -> am_locked=1 after the AM beat; exactly 1023 dout_valid beats; no pulses.
- Locked; suppress AM at beats 1024, 2048, 3072 (MISS_LIMIT=3) -> am_miss pulses x3; am_locked drops after the third; dout_valid 0 until the next all-lane AM.
- AM on lanes 0-2 only (lane 3 data) -> am_mismatch pulse; beat forwarded on dout; no lock change.
- din_fix=4'b1011 held for 10 cycles, clr_cnt asserted in the 11th cycle -> fix_cnt=30, then 0; with CNT_W=4, fix_cnt saturates at 15.
- deskew_locked deasserted mid-stream -> next cycle state IDLE, am_locked=0, dout_valid=0; re-lock requires a fresh all-lane AM.
- SL3_AM_LANE_ID_EN defined: lane 2 AM ID=5 -> am_lane_err pulse; in HUNT no lock is taken; AM beat absent from dout.

Source files
------------

// File: rtl/sl3_pkg.sv
// rtl/sl3_pkg.sv - shared constants and state type for the sl3 receive AM checker
// Used by sl3_rx_am_check and sl3_sat_popcnt_acc.
package sl3_pkg;

  localparam int         LANE_W   = 66;
  localparam logic [1:0] SH_CTRL  = 2'b01;
  localparam logic [3:0] AM_BTYPE = 4'b1100;

  // Bit offsets inside one 66-bit lane word
  localparam int AM_BT_LO = 34;
  localparam int AM_BT_W  = 4;
  localparam int AM_ID_LO = 38;
  localparam int AM_ID_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HUNT   = 2'd1,
    ST_LOCKED = 2'd2
  } am_state_e;

endpackage

// File: rtl/sl3_sat_popcnt_acc.sv
// rtl/sl3_sat_popcnt_acc.sv - popcount of a flag vector into a saturating counter
// Clear and reset both load zero and discard the current cycle's increment.
module sl3_sat_popcnt_acc #(
  parameter int N = 4,
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_srst,
  input  logic         i_clr,
  input  logic [N-1:0] i_flags,
  output logic [W-1:0] o_cnt
);

  localparam int PW = $clog2(N + 1);

  logic [PW-1:0] w_pop;
  logic [W:0]    w_sum;
  logic [W-1:0]  r_cnt;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < N; i++) begin
      w_pop = w_pop + PW'(i_flags[i]);
    end
  end

  // One extra bit catches the carry out so the counter pins at all-ones
  assign w_sum = {1'b0, r_cnt} + (W+1)'(w_pop);

  always_ff @(posedge i_clk) begin
    if (i_srst || i_clr) begin
      r_cnt <= '0;
    end else if (w_sum[W]) begin
      r_cnt <= '1;
    end else begin
      r_cnt <= w_sum[W-1:0];
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/sl3_rx_am_check.sv
// rtl/sl3_rx_am_check.sv - alignment-marker lock, strip and ECC error counting
// Optional lane-ID check of AM beats is enabled by defining SL3_AM_LANE_ID_EN.
module sl3_rx_am_check
  import sl3_pkg::*;
#(
  parameter int NUM_LN     = 4,
  parameter int AM_PERIOD  = 1024,
  parameter int MISS_LIMIT = 3,
  parameter int CNT_W      = 16
) (
  input  logic                     i_clk,
  input  logic                     i_srst,
  input  logic [NUM_LN*LANE_W-1:0] i_din,
  input  logic                     i_din_valid,
  input  logic [NUM_LN-1:0]        i_din_fix,
  input  logic [NUM_LN-1:0]        i_din_fail,
  input  logic                     i_deskew_locked,
  input  logic                     i_clr_cnt,
  output logic [NUM_LN*LANE_W-1:0] o_dout,
  output logic                     o_dout_valid,
  output logic                     o_am_locked,
  output logic                     o_am_miss,
  output logic                     o_am_mismatch,
  output logic                     o_am_lane_err,
  output logic [CNT_W-1:0]         o_fix_cnt,
  output logic [CNT_W-1:0]         o_fail_cnt
);

  localparam int PER_W = $clog2(AM_PERIOD);
  localparam int DW    = NUM_LN * LANE_W;

  logic [NUM_LN-1:0] w_lane_am;
  logic              w_all_am;
  logic              w_any_am;
  logic              w_id_err;
  logic              w_am_ok;
  logic              w_expected;
  logic              w_miss_evt;
  logic [2:0]        w_miss_inc;

  am_state_e         r_state;
  logic [PER_W-1:0]  r_beat_cnt;
  logic [2:0]        r_miss_cnt;
  logic [DW-1:0]     r_dout;
  logic              r_dout_valid;
  logic              r_am_locked;
  logic              r_am_miss;
  logic              r_am_mismatch;
  logic              r_am_lane_err;

  always_comb begin
    w_lane_am = '0;
    for (int i = 0; i < NUM_LN; i++) begin
      w_lane_am[i] = (i_din[i*LANE_W] == SH_CTRL[0]) &&
                     (i_din[i*LANE_W + AM_BT_LO +: AM_BT_W] == AM_BTYPE);
    end
  end

  assign w_all_am = &w_lane_am;
  assign w_any_am = |w_lane_am;

`ifdef SL3_AM_LANE_ID_EN
  logic [NUM_LN-1:0] w_lane_id_ok;

  always_comb begin
    w_lane_id_ok = '0;
    for (int i = 0; i < NUM_LN; i++) begin
      w_lane_id_ok[i] = (i_din[i*LANE_W + AM_ID_LO +: AM_ID_W] == AM_ID_W'(i));
    end
  end

  assign w_id_err = w_all_am && !(&w_lane_id_ok);
`else
  assign w_id_err = 1'b0;
`endif

  // A beat with a bad lane ID still counts as an AM for stripping, not for lock
  assign w_am_ok    = w_all_am && !w_id_err;
  assign w_expected = (r_beat_cnt == '0);
  assign w_miss_evt = (w_expected != w_am_ok);
  assign w_miss_inc = r_miss_cnt + 3'd1;

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_state       <= ST_IDLE;
      r_beat_cnt    <= '0;
      r_miss_cnt    <= '0;
      r_dout        <= '0;
      r_dout_valid  <= 1'b0;
      r_am_locked   <= 1'b0;
      r_am_miss     <= 1'b0;
      r_am_mismatch <= 1'b0;
      r_am_lane_err <= 1'b0;
    end else begin
      r_dout_valid  <= 1'b0;
      r_am_miss     <= 1'b0;
      r_am_mismatch <= 1'b0;
      r_am_lane_err <= 1'b0;
      if (!i_deskew_locked) begin
        r_state     <= ST_IDLE;
        r_am_locked <= 1'b0;
        r_miss_cnt  <= '0;
      end else begin
        if (i_din_valid && (r_state != ST_IDLE)) begin
          r_am_mismatch <= w_any_am && !w_all_am;
          r_am_lane_err <= w_id_err;
        end
        case (r_state)
          ST_IDLE: begin
            r_miss_cnt <= '0;
            r_state    <= ST_HUNT;
          end
          ST_HUNT: begin
            if (i_din_valid && w_am_ok) begin
              r_state     <= ST_LOCKED;
              r_am_locked <= 1'b1;
              r_beat_cnt  <= PER_W'(1);
              r_miss_cnt  <= '0;
            end
          end
          ST_LOCKED: begin
            if (i_din_valid) begin
              r_dout_valid <= !w_all_am;
              if (!w_all_am) begin
                r_dout <= i_din;
              end
              // An early AM realigns the period to start from this beat
              r_beat_cnt <= (!w_expected && w_am_ok) ? PER_W'(1)
                                                     : r_beat_cnt + PER_W'(1);
              if (w_miss_evt) begin
                r_am_miss <= 1'b1;
                if (w_miss_inc == 3'(MISS_LIMIT)) begin
                  r_state     <= ST_HUNT;
                  r_am_locked <= 1'b0;
                  r_miss_cnt  <= '0;
                end else begin
                  r_miss_cnt <= w_miss_inc;
                end
              end else if (w_expected) begin
                r_miss_cnt <= '0;
              end
            end
          end
          default: begin
            r_state     <= ST_IDLE;
            r_am_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  sl3_sat_popcnt_acc #(.N(NUM_LN), .W(CNT_W)) u_fix_acc (
    .i_clk   (i_clk),
    .i_srst  (i_srst),
    .i_clr   (i_clr_cnt),
    .i_flags (i_din_fix),
    .o_cnt   (o_fix_cnt)
  );

  sl3_sat_popcnt_acc #(.N(NUM_LN), .W(CNT_W)) u_fail_acc (
    .i_clk   (i_clk),
    .i_srst  (i_srst),
    .i_clr   (i_clr_cnt),
    .i_flags (i_din_fail),
    .o_cnt   (o_fail_cnt)
  );

  assign o_dout        = r_dout;
  assign o_dout_valid  = r_dout_valid;
  assign o_am_locked   = r_am_locked;
  assign o_am_miss     = r_am_miss;
  assign o_am_mismatch = r_am_mismatch;
  assign o_am_lane_err = r_am_lane_err;

endmodule

// File: tb/tb_sl3_rx_am_check.sv
// tb/tb_sl3_rx_am_check.sv - directed bench for sl3_rx_am_check
// Adds lane-ID cases when SL3_AM_LANE_ID_EN is defined.
module tb_sl3_rx_am_check;

  localparam int NL = 4;
  localparam int DW = NL * 66;

  logic          clk = 1'b0;
  logic          srst;
  logic [DW-1:0] din;
  logic          din_valid;
  logic [NL-1:0] din_fix;
  logic [NL-1:0] din_fail;
  logic          deskew_locked;
  logic          clr_cnt;

  logic [DW-1:0] dout;
  logic          dout_valid, am_locked, am_miss, am_mismatch, am_lane_err;
  logic [15:0]   fix_cnt, fail_cnt;

  logic [DW-1:0] dout4;
  logic          dout_valid4, am_locked4, am_miss4, am_mismatch4, am_lane_err4;
  logic [3:0]    fix_cnt4, fail_cnt4;

  int n_vec = 0;
  int n_err = 0;
  int n_dv, n_miss, n_mm, n_le, n_bad_dout;

  always #5 clk = ~clk;

  sl3_rx_am_check u_dut (
    .i_clk(clk), .i_srst(srst), .i_din(din), .i_din_valid(din_valid),
    .i_din_fix(din_fix), .i_din_fail(din_fail), .i_deskew_locked(deskew_locked),
    .i_clr_cnt(clr_cnt), .o_dout(dout), .o_dout_valid(dout_valid),
    .o_am_locked(am_locked), .o_am_miss(am_miss), .o_am_mismatch(am_mismatch),
    .o_am_lane_err(am_lane_err), .o_fix_cnt(fix_cnt), .o_fail_cnt(fail_cnt)
  );

  // Narrow-counter instance for saturation
  sl3_rx_am_check #(.CNT_W(4)) u_dut4 (
    .i_clk(clk), .i_srst(srst), .i_din(din), .i_din_valid(din_valid),
    .i_din_fix(din_fix), .i_din_fail(din_fail), .i_deskew_locked(deskew_locked),
    .i_clr_cnt(clr_cnt), .o_dout(dout4), .o_dout_valid(dout_valid4),
    .o_am_locked(am_locked4), .o_am_miss(am_miss4), .o_am_mismatch(am_mismatch4),
    .o_am_lane_err(am_lane_err4), .o_fix_cnt(fix_cnt4), .o_fail_cnt(fail_cnt4)
  );

  typedef struct {
    logic       dsk, vld, clr;
    logic [3:0] am, fix, fail;
    logic       e_lock, e_dv, e_miss, e_mm;
    int         e_fix, e_fail, e_fix4;
  } vec_t;

  vec_t tbl[26];

  function automatic vec_t mkv(input logic dsk, input logic vld, input logic [3:0] am,
                               input logic [3:0] fix, input logic [3:0] fail, input logic clr,
                               input logic lk, input logic dv, input logic ms, input logic mm,
                               input int efix, input int efail, input int efix4);
    vec_t v;
    v.dsk = dsk; v.vld = vld; v.am = am; v.fix = fix; v.fail = fail; v.clr = clr;
    v.e_lock = lk; v.e_dv = dv; v.e_miss = ms; v.e_mm = mm;
    v.e_fix = efix; v.e_fail = efail; v.e_fix4 = efix4;
    return v;
  endfunction

  // Data lanes carry header 2'b10; AM lanes carry 2'b01, type 1100 and lane ID
  function automatic logic [DW-1:0] mk_word(input logic [3:0] am_mask, input int bad_lane,
                                            input logic [7:0] bad_id, input int seed);
    logic [DW-1:0] w;
    logic [65:0]   ln;
    for (int i = 0; i < NL; i++) begin
      ln = {32'(seed * 7 + i), 32'(seed) ^ 32'h5a5a_0000 ^ 32'(i), 2'b10};
      if (am_mask[i]) begin
        ln[1:0]   = 2'b01;
        ln[37:34] = 4'b1100;
        ln[45:38] = (i == bad_lane) ? bad_id : 8'(i);
      end
      w[i*66 +: 66] = ln;
    end
    return w;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [DW-1:0] w);
    din       = w;
    din_valid = v;
    @(posedge clk);
    #1;
    if (dout_valid) begin
      n_dv++;
      if (dout !== w) n_bad_dout++;
    end
    if (am_miss) n_miss++;
    if (am_mismatch) n_mm++;
    if (am_lane_err) n_le++;
  endtask

  task automatic clr_stats();
    n_dv = 0; n_miss = 0; n_mm = 0; n_le = 0; n_bad_dout = 0;
  endtask

  task automatic do_reset();
    srst = 1'b1; din = '0; din_valid = 1'b0; din_fix = '0; din_fail = '0;
    deskew_locked = 1'b0; clr_cnt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    srst = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] w;
    vec_t v;

    // Table: counters, hunt, partial AM, early AM, deskew loss
    tbl[0]  = mkv(0,0,4'h0,4'b1011,4'h0,0, 0,0,0,0,  3,0, 3);
    tbl[1]  = mkv(0,0,4'h0,4'b1011,4'h0,0, 0,0,0,0,  6,0, 6);
    tbl[2]  = mkv(0,0,4'h0,4'b1011,4'h0,0, 0,0,0,0,  9,0, 9);
    tbl[3]  = mkv(0,0,4'h0,4'b1011,4'h0,0, 0,0,0,0, 12,0,12);
    tbl[4]  = mkv(0,0,4'h0,4'b1011,4'h0,0, 0,0,0,0, 15,0,15);
    tbl[5]  = mkv(0,0,4'h0,4'b1011,4'h0,0, 0,0,0,0, 18,0,15);
    tbl[6]  = mkv(0,0,4'h0,4'b1011,4'h0,0, 0,0,0,0, 21,0,15);
    tbl[7]  = mkv(0,0,4'h0,4'b1011,4'h0,0, 0,0,0,0, 24,0,15);
    tbl[8]  = mkv(0,0,4'h0,4'b1011,4'h0,0, 0,0,0,0, 27,0,15);
    tbl[9]  = mkv(0,0,4'h0,4'b1011,4'h0,0, 0,0,0,0, 30,0,15);
    tbl[10] = mkv(0,0,4'h0,4'b1011,4'h0,1, 0,0,0,0,  0,0, 0);
    tbl[11] = mkv(0,0,4'h0,4'h0,4'b0110,0, 0,0,0,0,  0,2, 0);
    tbl[12] = mkv(1,0,4'h0,4'h0,4'h0,0,    0,0,0,0,  0,2, 0);
    tbl[13] = mkv(1,1,4'h0,4'h0,4'h0,0,    0,0,0,0,  0,2, 0);
    tbl[14] = mkv(1,1,4'h7,4'h0,4'h0,0,    0,0,0,1,  0,2, 0);
    tbl[15] = mkv(1,0,4'h0,4'h0,4'h0,0,    0,0,0,0,  0,2, 0);
    tbl[16] = mkv(1,1,4'hF,4'h0,4'h0,0,    1,0,0,0,  0,2, 0);
    tbl[17] = mkv(1,0,4'h0,4'h0,4'h0,0,    1,0,0,0,  0,2, 0);
    tbl[18] = mkv(1,1,4'h0,4'h0,4'h0,0,    1,1,0,0,  0,2, 0);
    tbl[19] = mkv(1,0,4'h0,4'h0,4'h0,0,    1,0,0,0,  0,2, 0);
    tbl[20] = mkv(1,1,4'h7,4'h1,4'hF,0,    1,1,0,1,  1,6, 1);
    tbl[21] = mkv(1,1,4'hF,4'h1,4'h0,0,    1,0,1,0,  2,6, 2);
    tbl[22] = mkv(0,1,4'hF,4'h0,4'h0,0,    0,0,0,0,  2,6, 2);
    tbl[23] = mkv(0,1,4'h0,4'h0,4'h0,0,    0,0,0,0,  2,6, 2);
    tbl[24] = mkv(1,0,4'h0,4'h0,4'h0,0,    0,0,0,0,  2,6, 2);
    tbl[25] = mkv(1,1,4'h0,4'h0,4'h0,0,    0,0,0,0,  2,6, 2);

    do_reset();
    chk("rst.am_locked",   int'(am_locked), 0);
    chk("rst.dout_valid",  int'(dout_valid), 0);
    chk("rst.dout_zero",   int'(dout == '0), 1);
    chk("rst.pulses",      int'({am_miss, am_mismatch, am_lane_err}), 0);
    chk("rst.fix_cnt",     int'(fix_cnt), 0);
    chk("rst.fail_cnt",    int'(fail_cnt), 0);

    for (int k = 0; k < 26; k++) begin
      v = tbl[k];
      w = mk_word(v.am, -1, 8'd0, k + 1);
      din = w; din_valid = v.vld; deskew_locked = v.dsk;
      din_fix = v.fix; din_fail = v.fail; clr_cnt = v.clr;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.am_locked", k),   int'(am_locked),   int'(v.e_lock));
      chk($sformatf("v%0d.dout_valid", k),  int'(dout_valid),  int'(v.e_dv));
      chk($sformatf("v%0d.am_miss", k),     int'(am_miss),     int'(v.e_miss));
      chk($sformatf("v%0d.am_mismatch", k), int'(am_mismatch), int'(v.e_mm));
      chk($sformatf("v%0d.am_lane_err", k), int'(am_lane_err), 0);
      chk($sformatf("v%0d.fix_cnt", k),     int'(fix_cnt),     v.e_fix);
      chk($sformatf("v%0d.fail_cnt", k),    int'(fail_cnt),    v.e_fail);
      chk($sformatf("v%0d.fix_cnt4", k),    int'(fix_cnt4),    v.e_fix4);
      if (v.e_dv) chk($sformatf("v%0d.dout", k), int'(dout == w), 1);
    end
    din_fix = '0; din_fail = '0; clr_cnt = 1'b0;

    // Full period: AM then 1023 data beats, valid every other cycle
    do_reset();
    deskew_locked = 1'b1;
    step(1'b0, '0);
    clr_stats();
    step(1'b1, mk_word(4'hF, -1, 8'd0, 100));
    chk("p0.lock_after_am", int'(am_locked), 1);
    step(1'b0, '0);
    for (int b = 1; b < 1024; b++) begin
      step(1'b1, mk_word(4'h0, -1, 8'd0, b));
      step(1'b0, '0);
    end
    chk("p0.dv_count",  n_dv, 1023);
    chk("p0.bad_dout",  n_bad_dout, 0);
    chk("p0.pulses",    n_miss + n_mm + n_le, 0);
    chk("p0.locked",    int'(am_locked), 1);

    // Suppress AM at beats 1024/2048/3072: three misses then HUNT
    clr_stats();
    for (int b = 1024; b <= 3072; b++) begin
      step(1'b1, mk_word(4'h0, -1, 8'd0, b));
      if ((b % 1024) == 0) begin
        chk($sformatf("miss@%0d.am_miss", b), int'(am_miss), 1);
        chk($sformatf("miss@%0d.am_locked", b), int'(am_locked), (b == 3072) ? 0 : 1);
      end
      step(1'b0, '0);
    end
    chk("miss.count",    n_miss, 3);
    chk("miss.dv_count", n_dv, 2049);
    chk("miss.bad_dout", n_bad_dout, 0);
    clr_stats();
    for (int b = 0; b < 8; b++) begin
      step(1'b1, mk_word(4'h0, -1, 8'd0, 5000 + b));
      step(1'b0, '0);
    end
    chk("hunt.dv_count", n_dv, 0);
    chk("hunt.locked",   int'(am_locked), 0);
    step(1'b1, mk_word(4'hF, -1, 8'd0, 6000));
    chk("relock.locked", int'(am_locked), 1);
    chk("relock.dv",     int'(dout_valid), 0);

`ifdef SL3_AM_LANE_ID_EN
    // Bad lane-2 ID in HUNT: error pulse, no lock, beat stripped
    do_reset();
    deskew_locked = 1'b1;
    step(1'b0, '0);
    step(1'b1, mk_word(4'hF, 2, 8'd5, 7000));
    chk("lid.lane_err", int'(am_lane_err), 1);
    chk("lid.no_lock",  int'(am_locked), 0);
    chk("lid.dv",       int'(dout_valid), 0);
    step(1'b0, '0);
    step(1'b1, mk_word(4'hF, -1, 8'd0, 7001));
    chk("lid.good_lock", int'(am_locked), 1);
    chk("lid.no_err",    int'(am_lane_err), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
